// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   seq_state_e : sequencer FSM states (RUN, MEM_WAIT)
//   CSEL_*      : encoding of the C_Unit_MUX select into ID/EX
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } seq_state_e;

  // C_Unit_MUX = 1 injects the NOP control word (bubble) into ID/EX.
  localparam logic CSEL_NORMAL = 1'b0;
  localparam logic CSEL_NOP    = 1'b1;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if
// Control bus between the hazard/branch/memory sources and the sequencer.
//   master : drives the requests (load_use_hz, branch_taken, mem_req, clr_stats)
//            and observes the pipeline controls and statistics
//   slave  : the sequencer; consumes requests, drives controls and statistics
// Parameter CNT_W sets the width of the statistics counters.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             load_use_hz;
  logic             branch_taken;
  logic             mem_req;
  logic             clr_stats;
  logic             PC_ld;
  logic             IF_ID_ld;
  logic             IF_ID_clr;
  logic             ID_EX_ld;
  logic             C_Unit_MUX;
  logic             EX_MEM_ld;
  logic             MEM_WB_ld;
  logic             mem_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output load_use_hz, branch_taken, mem_req, clr_stats,
    input  PC_ld, IF_ID_ld, IF_ID_clr, ID_EX_ld, C_Unit_MUX,
           EX_MEM_ld, MEM_WB_ld, mem_busy, stall_cycles, flush_count
  );

  modport slave (
    input  load_use_hz, branch_taken, mem_req, clr_stats,
    output PC_ld, IF_ID_ld, IF_ID_clr, ID_EX_ld, C_Unit_MUX,
           EX_MEM_ld, MEM_WB_ld, mem_busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_sequencer_sat_counter.sv
// sat_counter
// W-bit up counter that sticks at all-ones; a synchronous clear wins over
// an increment in the same cycle.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear
//   inc      : count this cycle
//   q        : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Saturating count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central stall/flush controller for the 5-stage pipeline. Merges the
// load-use stall, the taken-branch flush and multi-cycle data-memory waits
// into PC / pipeline-register load and flush controls, and keeps saturating
// stall and flush statistics.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : pipeline_sequencer_if.slave (requests in, controls/stats out)
// Parameters: MEM_LAT (data-memory latency, >=1; 1 disables waiting),
//             CNT_W (statistics counter width, must match bus CNT_W).
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input logic                 CLK,
  input logic                 RST,
  pipeline_sequencer_if.slave bus
);

  localparam int                WCNT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam bit                WAIT_EN   = (MEM_LAT >= 2);
  // The cycle that enters MEM_WAIT is already the first frozen cycle.
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);

  seq_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic freeze_s;
  logic pc_ld_s, ifid_ld_s, ifid_clr_s, idex_ld_s, csel_s;
  logic exmem_ld_s, memwb_ld_s, busy_s;

  // Freeze: a new memory access in RUN, or a wait that is not yet finished.
  // The release cycle (MEM_WAIT, wcnt=0) ignores mem_req.
  always_comb begin
    freeze_s = 1'b0;
    if (WAIT_EN) begin
      if (state_q == RUN) begin
        freeze_s = bus.mem_req;
      end else begin
        freeze_s = (wcnt_q != '0);
      end
    end else begin
      freeze_s = 1'b0;
    end
  end

  // Pipeline controls: freeze overrides everything, then load-use, then branch.
  always_comb begin
    pc_ld_s    = 1'b1;
    ifid_ld_s  = 1'b1;
    ifid_clr_s = 1'b0;
    idex_ld_s  = 1'b1;
    csel_s     = CSEL_NORMAL;
    exmem_ld_s = 1'b1;
    memwb_ld_s = 1'b1;
    busy_s     = 1'b0;
    if (freeze_s) begin
      pc_ld_s    = 1'b0;
      ifid_ld_s  = 1'b0;
      idex_ld_s  = 1'b0;
      exmem_ld_s = 1'b0;
      memwb_ld_s = 1'b0;
      busy_s     = 1'b1;
    end else if (bus.load_use_hz) begin
      // Branch is ignored: it is still held in ID behind the bubble.
      pc_ld_s   = 1'b0;
      ifid_ld_s = 1'b0;
      csel_s    = CSEL_NOP;
    end else if (bus.branch_taken) begin
      ifid_clr_s = 1'b1;
    end else begin
      ifid_clr_s = 1'b0;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (freeze_s) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_LOAD;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.PC_ld      = pc_ld_s;
  assign bus.IF_ID_ld   = ifid_ld_s;
  assign bus.IF_ID_clr  = ifid_clr_s;
  assign bus.ID_EX_ld   = idex_ld_s;
  assign bus.C_Unit_MUX = csel_s;
  assign bus.EX_MEM_ld  = exmem_ld_s;
  assign bus.MEM_WB_ld  = memwb_ld_s;
  assign bus.mem_busy   = busy_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (bus.clr_stats),
    .inc (busy_s | (csel_s == CSEL_NOP)),
    .q   (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (bus.clr_stats),
    .inc (ifid_clr_s),
    .q   (bus.flush_count)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Directed bench for pipeline_sequencer. Three instances:
//   a : MEM_LAT=3, CNT_W=16  (freeze timing, load-use/branch, reset mid-wait)
//   b : MEM_LAT=2, CNT_W=4   (branch held through a freeze, saturation, clear)
//   c : MEM_LAT=1, CNT_W=8   (no freeze ever)
// Control vector order: {PC_ld, IF_ID_ld, IF_ID_clr, ID_EX_ld, C_Unit_MUX,
//                        EX_MEM_ld, MEM_WB_ld, mem_busy}
module tb_pipeline_sequencer;

  logic CLK = 1'b0;
  logic rst_a, rst_b, rst_c;

  always #5 CLK = ~CLK;

  pipeline_sequencer_if #(.CNT_W(16)) ifa ();
  pipeline_sequencer_if #(.CNT_W(4))  ifb ();
  pipeline_sequencer_if #(.CNT_W(8))  ifc ();

  pipeline_sequencer #(.MEM_LAT(3), .CNT_W(16)) u_dut_a (.CLK(CLK), .RST(rst_a), .bus(ifa.slave));
  pipeline_sequencer #(.MEM_LAT(2), .CNT_W(4))  u_dut_b (.CLK(CLK), .RST(rst_b), .bus(ifb.slave));
  pipeline_sequencer #(.MEM_LAT(1), .CNT_W(8))  u_dut_c (.CLK(CLK), .RST(rst_c), .bus(ifc.slave));

  localparam logic [7:0] CTL_RUN = 8'b1101_0110;
  localparam logic [7:0] CTL_FRZ = 8'b0000_0001;
  localparam logic [7:0] CTL_LU  = 8'b0001_1110;
  localparam logic [7:0] CTL_BR  = 8'b1111_0110;

  logic [7:0] ctl_a, ctl_b, ctl_c;
  assign ctl_a = {ifa.PC_ld, ifa.IF_ID_ld, ifa.IF_ID_clr, ifa.ID_EX_ld,
                  ifa.C_Unit_MUX, ifa.EX_MEM_ld, ifa.MEM_WB_ld, ifa.mem_busy};
  assign ctl_b = {ifb.PC_ld, ifb.IF_ID_ld, ifb.IF_ID_clr, ifb.ID_EX_ld,
                  ifb.C_Unit_MUX, ifb.EX_MEM_ld, ifb.MEM_WB_ld, ifb.mem_busy};
  assign ctl_c = {ifc.PC_ld, ifc.IF_ID_ld, ifc.IF_ID_clr, ifc.ID_EX_ld,
                  ifc.C_Unit_MUX, ifc.EX_MEM_ld, ifc.MEM_WB_ld, ifc.mem_busy};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Outputs are sampled on the falling edge.
  task automatic sample();
    @(negedge CLK);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.load_use_hz = 1'b0; ifa.branch_taken = 1'b0; ifa.mem_req = 1'b0; ifa.clr_stats = 1'b0;
    ifb.load_use_hz = 1'b0; ifb.branch_taken = 1'b0; ifb.mem_req = 1'b0; ifb.clr_stats = 1'b0;
    ifc.load_use_hz = 1'b0; ifc.branch_taken = 1'b0; ifc.mem_req = 1'b0; ifc.clr_stats = 1'b0;

    // Reset state
    sample();
    check("rst_ctl_a",   32'(ctl_a), 32'(CTL_RUN));
    check("rst_stall_a", 32'(ifa.stall_cycles), 32'd0);
    check("rst_flush_a", 32'(ifa.flush_count), 32'd0);
    check("rst_ctl_b",   32'(ctl_b), 32'(CTL_RUN));
    next_cycle();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) next_cycle();

    // MEM_LAT=3: two frozen cycles, then advance; back-to-back repeats
    ifa.mem_req = 1'b1;
    sample(); check("a_frz1", 32'(ctl_a), 32'(CTL_FRZ));
    next_cycle(); sample(); check("a_frz2", 32'(ctl_a), 32'(CTL_FRZ));
    next_cycle(); sample(); check("a_release", 32'(ctl_a), 32'(CTL_RUN));
    check("a_stall2", 32'(ifa.stall_cycles), 32'd2);
    next_cycle(); sample(); check("a_b2b_frz1", 32'(ctl_a), 32'(CTL_FRZ));
    next_cycle(); sample(); check("a_b2b_frz2", 32'(ctl_a), 32'(CTL_FRZ));
    next_cycle(); ifa.mem_req = 1'b0;
    sample(); check("a_b2b_release", 32'(ctl_a), 32'(CTL_RUN));
    check("a_stall4", 32'(ifa.stall_cycles), 32'd4);

    // Load-use wins over branch, then branch alone flushes
    next_cycle(); ifa.load_use_hz = 1'b1; ifa.branch_taken = 1'b1;
    sample(); check("a_lu_and_br", 32'(ctl_a), 32'(CTL_LU));
    next_cycle(); ifa.load_use_hz = 1'b0;
    sample(); check("a_br_only", 32'(ctl_a), 32'(CTL_BR));
    next_cycle(); ifa.branch_taken = 1'b0;
    sample(); check("a_idle", 32'(ctl_a), 32'(CTL_RUN));
    check("a_flush1", 32'(ifa.flush_count), 32'd1);
    check("a_stall5", 32'(ifa.stall_cycles), 32'd5);

    // Reset mid-wait (MEM_WAIT, wcnt=1) aborts the wait immediately
    next_cycle(); ifa.mem_req = 1'b1;
    sample(); check("a_frz_pre_rst", 32'(ctl_a), 32'(CTL_FRZ));
    next_cycle(); ifa.mem_req = 1'b0;
    #1; check("a_wait_wcnt1", 32'(ctl_a), 32'(CTL_FRZ));
    rst_a = 1'b1;
    #1; check("a_rst_ctl", 32'(ctl_a), 32'(CTL_RUN));
    check("a_rst_stall", 32'(ifa.stall_cycles), 32'd0);
    check("a_rst_flush", 32'(ifa.flush_count), 32'd0);
    #1; rst_a = 1'b0;
    sample(); check("a_post_rst1", 32'(ctl_a), 32'(CTL_RUN));
    next_cycle(); sample(); check("a_post_rst2", 32'(ctl_a), 32'(CTL_RUN));

    // MEM_LAT=2: branch held through the freeze acts only at release
    next_cycle(); ifb.mem_req = 1'b1; ifb.branch_taken = 1'b1;
    sample(); check("b_frz_br", 32'(ctl_b), 32'(CTL_FRZ));
    next_cycle(); sample(); check("b_release_br", 32'(ctl_b), 32'(CTL_BR));
    next_cycle(); ifb.mem_req = 1'b0; ifb.branch_taken = 1'b0;
    sample(); check("b_idle", 32'(ctl_b), 32'(CTL_RUN));
    check("b_flush1", 32'(ifb.flush_count), 32'd1);
    check("b_stall1", 32'(ifb.stall_cycles), 32'd1);

    // CNT_W=4: 20 bubble cycles saturate stall_cycles at 15
    ifb.load_use_hz = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (i == 0) check("b_lu_ctl", 32'(ctl_b), 32'(CTL_LU));
      next_cycle();
    end
    ifb.load_use_hz = 1'b0;
    sample(); check("b_sat15", 32'(ifb.stall_cycles), 32'd15);
    check("b_flush_hold", 32'(ifb.flush_count), 32'd1);

    // Clear takes priority over a simultaneous increment
    next_cycle(); ifb.clr_stats = 1'b1; ifb.load_use_hz = 1'b1;
    next_cycle(); ifb.clr_stats = 1'b0; ifb.load_use_hz = 1'b0;
    sample(); check("b_clr_stall", 32'(ifb.stall_cycles), 32'd0);
    check("b_clr_flush", 32'(ifb.flush_count), 32'd0);

    // MEM_LAT=1: mem_req never freezes
    next_cycle(); ifc.mem_req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      sample(); check("c_no_frz", 32'(ctl_c), 32'(CTL_RUN));
      next_cycle();
    end
    ifc.mem_req = 1'b0;
    sample(); check("c_stall0", 32'(ifc.stall_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush controller for the 5-stage ARM pipeline. It merges the load-use stall request from the hazard unit, the taken-branch indication from ID, and multi-cycle data-memory accesses into one consistent set of PC and pipeline-register load and flush controls. It also keeps saturating stall and flush statistics for debug.

## Interface

Parameters:
- MEM_LAT, 2: data-memory access latency in cycles; legal range ≥1. Latency 1 disables the wait FSM.
- CNT_W, 16: width of each statistics counter.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- load_use_hz  in  1  load in EX feeds a source register in ID (hazard unit stall request)
- branch_taken  in  1  branch in ID resolved taken this cycle
- mem_req  in  1  instruction in MEM performs a data-memory load/store
- clr_stats  in  1  synchronous clear of both statistics counters
- PC_ld  out  1  PC load enable
- IF_ID_ld  out  1  IF/ID register load enable
- IF_ID_clr  out  1  IF/ID flush (loads a NOP)
- ID_EX_ld  out  1  ID/EX register load enable
- C_Unit_MUX  out  1  select NOP control word into ID/EX (bubble)
- EX_MEM_ld  out  1  EX/MEM load enable
- MEM_WB_ld  out  1  MEM/WB load enable
- mem_busy  out  1  pipeline frozen waiting on memory
- stall_cycles  out  CNT_W  count of cycles with a freeze or bubble, saturating
- flush_count  out  CNT_W  count of IF/ID flushes, saturating

## Operation

- Outputs are combinational from the registered state plus current inputs. State, wait counter and statistics are registered.
- States:
  - RUN
  - MEM_WAIT, with wait counter wcnt of width $clog2(MEM_LAT).
- Freeze condition, in RUN with mem_req=1 and MEM_LAT≥2:
  - All *_ld=0, IF_ID_clr=0, C_Unit_MUX=0, mem_busy=1.
  - Next state MEM_WAIT; wcnt←MEM_LAT-2.
- MEM_WAIT with wcnt≠0: same freeze outputs; wcnt decrements.
- MEM_WAIT with wcnt=0 (release cycle):
  - mem_req is ignored; mem_busy=0.
  - Load-use and branch are evaluated as in RUN.
  - Next state RUN.
- Normal evaluation (RUN without freeze, or the release cycle), in priority order:
  1. load_use_hz=1: PC_ld=0, IF_ID_ld=0, ID_EX_ld=1, C_Unit_MUX=1, EX_MEM_ld=1, MEM_WB_ld=1. branch_taken is ignored, because the branch is still held in ID.
  2. branch_taken=1: all *_ld=1, IF_ID_clr=1, C_Unit_MUX=0.
  3. Otherwise: all *_ld=1, IF_ID_clr=0, C_Unit_MUX=0.
- While frozen, load_use_hz and branch_taken are ignored. They persist and are acted on at release.
- Statistics:
  - stall_cycles increments in every cycle with mem_busy=1 or C_Unit_MUX=1.
  - flush_count increments in every cycle with IF_ID_clr=1.
  - Both counters saturate at all-ones.
  - clr_stats=1 forces both to 0 on the next edge and takes priority over increment.
- With MEM_LAT=1: no freeze ever, the FSM stays in RUN, and mem_busy is tied 0.

## Timing

- Reset (RST=1, asynchronous): state=RUN, wcnt=0, stall_cycles=0, flush_count=0. Outputs then follow the RUN rules from the current inputs. RST asserted mid-wait aborts the wait immediately.
- Memory access with MEM_LAT=N≥2:
  - Freeze for exactly N-1 consecutive cycles, starting in the cycle mem_req is first seen in RUN.
  - The pipeline advances in the Nth cycle.
  - A new mem_req seen in the following cycle starts a fresh wait.
- Back-to-back memory instructions: N-1 frozen cycles, then 1 advance cycle, then N-1 frozen cycles, repeating.
- A load-use bubble lasts 1 cycle, because the hazard unit deasserts load_use_hz once the load leaves EX.
- Branch flush: 1 cycle, no freeze.

## Structure

- Shared package pipeline_ctrl_pkg holds:
  - the state enum {RUN, MEM_WAIT};
  - localparam NOP control-select encoding (C_Unit_MUX=1 means NOP).
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, clr, inc; output q), instantiated twice for the statistics.

## Test plan

- Reset with all inputs 0 → all *_ld=1, IF_ID_clr=0, C_Unit_MUX=0, mem_busy=0, both counters 0.
- MEM_LAT=3, mem_req=1 held at cycle 5 → mem_busy=1 and all *_ld=0 in cycles 5–6; all *_ld=1 in cycle 7; stall_cycles=2.
- load_use_hz=1 and branch_taken=1 together for 1 cycle → PC_ld=0, IF_ID_ld=0, C_Unit_MUX=1, IF_ID_clr=0. Next cycle with branch_taken=1 only → IF_ID_clr=1, flush_count=1.
- branch_taken=1 during a freeze and held through release (MEM_LAT=2) → IF_ID_clr=0 while frozen, IF_ID_clr=1 only in the release cycle.
- RST pulsed while in MEM_WAIT with wcnt=1 → state RUN immediately, mem_busy=0 with mem_req=0, counters 0.
- CNT_W=4, continuous load_use_hz=1 for 20 cycles → stall_cycles stops at 15. clr_stats=1 → 0 next cycle.
